twiddle_angle_encoder: RTL and testbench

- Inverse of the FFT-384 twiddle ROM decoder. Takes a complex Q2.14 twiddle/phasor {re,im} and returns the nearest 4-bit phase index k, where angle = k*pi/8 (k=0: +1+j0, k=4: 0+j1).
- Used to compress twiddle tables into angle ROM images and to check decoder output in loopback.
- Three-stage pipeline with valid/ready handshakes on both sides.

---
 rtl/twiddle_pkg.sv | 72 +++++++
 rtl/twiddle_octant_cmp.sv | 31 +++
 rtl/twiddle_angle_encoder.sv | 169 ++++++++++++++++
 tb/tb_twiddle_angle_encoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/twiddle_pkg.sv
// Shared Q2.14 twiddle constants, angle/sample types and the index -> {cos,sin} table.
// Latency: n/a (package only).
// Backpressure: n/a. The table function is shared with the ROM decoder and the TWIDDLE_ANGLE_EXACT_EN path.
package twiddle_pkg;

    localparam int COS_SIN    = 16;
    localparam int FLT_BIT    = 14;
    localparam int TAN_PI_16  = 3259;
    localparam int TAN_3PI_16 = 10947;

    typedef logic [3:0]         angle_idx_t;
    typedef logic signed [15:0] q2_14_t;

    localparam q2_14_t COS_0        = 16'sd16384;
    localparam q2_14_t COS_PI_8     = 16'sd15136;
    localparam q2_14_t COS_PI_4     = 16'sd11585;
    localparam q2_14_t SIN_PI_8     = 16'sd6269;
    localparam q2_14_t NEG_COS_0    = -16'sd16384;
    localparam q2_14_t NEG_COS_PI_8 = -16'sd15136;
    localparam q2_14_t NEG_COS_PI_4 = -16'sd11585;
    localparam q2_14_t NEG_SIN_PI_8 = -16'sd6269;
    localparam q2_14_t ZERO_Q       = 16'sd0;

    // Complex sample, re in the MSBs to match the din bus layout
    typedef struct packed {
        q2_14_t re;
        q2_14_t im;
    } cplx_t;

    // S1 fold result: signs, octant swap flag, magnitudes ordered max/min
    typedef struct packed {
        logic               sr;
        logic               si;
        logic               sw;
        logic               zero;
        logic [COS_SIN-1:0] x;
        logic [COS_SIN-1:0] y;
    } fold_t;

    // S2 result: signs plus the first-quadrant index j (0..4)
    typedef struct packed {
        logic       sr;
        logic       si;
        logic       zero;
        logic [2:0] j;
    } sub_t;

    // Decoder constant pair for angle k*pi/8
    function automatic cplx_t cos_sin(input angle_idx_t k);
        cplx_t r;
        case (k)
            4'd0:    r = '{re: COS_0,        im: ZERO_Q};
            4'd1:    r = '{re: COS_PI_8,     im: SIN_PI_8};
            4'd2:    r = '{re: COS_PI_4,     im: COS_PI_4};
            4'd3:    r = '{re: SIN_PI_8,     im: COS_PI_8};
            4'd4:    r = '{re: ZERO_Q,       im: COS_0};
            4'd5:    r = '{re: NEG_SIN_PI_8, im: COS_PI_8};
            4'd6:    r = '{re: NEG_COS_PI_4, im: COS_PI_4};
            4'd7:    r = '{re: NEG_COS_PI_8, im: SIN_PI_8};
            4'd8:    r = '{re: NEG_COS_0,    im: ZERO_Q};
            4'd9:    r = '{re: NEG_COS_PI_8, im: NEG_SIN_PI_8};
            4'd10:   r = '{re: NEG_COS_PI_4, im: NEG_COS_PI_4};
            4'd11:   r = '{re: NEG_SIN_PI_8, im: NEG_COS_PI_8};
            4'd12:   r = '{re: ZERO_Q,       im: NEG_COS_0};
            4'd13:   r = '{re: SIN_PI_8,     im: NEG_COS_PI_8};
            4'd14:   r = '{re: COS_PI_4,     im: NEG_COS_PI_4};
            default: r = '{re: COS_PI_8,     im: NEG_SIN_PI_8};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/twiddle_octant_cmp.sv
// Picks the sub-sector 0..2 of a first-octant point (x>=y>=0) against tan(pi/16), tan(3pi/16).
// Latency: combinational.
// Backpressure: none; pure function of x and y. Ties resolve to the higher sub-sector.
module twiddle_octant_cmp
    import twiddle_pkg::*;
(
    input  logic [COS_SIN-1:0] x,
    input  logic [COS_SIN-1:0] y,
    output logic [1:0]         s
);

    logic [29:0] p;
    logic [29:0] q1;
    logic [29:0] q3;

    // y/x >= tan(theta) rewritten as y*2^14 >= x*round(tan(theta)*2^14), no divider
    assign p  = {y, {FLT_BIT{1'b0}}};
    assign q1 = {14'd0, x} * 30'(TAN_PI_16);
    assign q3 = {14'd0, x} * 30'(TAN_3PI_16);

    // Threshold ladder, highest boundary first so equality lands in the upper sector
    always_comb begin
        s = 2'd0;
        if (p >= q3) begin
            s = 2'd2;
        end else if (p >= q1) begin
            s = 2'd1;
        end
    end

endmodule

// File: rtl/twiddle_angle_encoder.sv
// Maps a Q2.14 {re,im} phasor to the nearest k*pi/8 index; optional exact-match flag under TWIDDLE_ANGLE_EXACT_EN.
// Latency: 3 cycles (fold, sub-sector, quadrant map), one sample per cycle.
// Backpressure: each stage loads when empty or draining; din_rdy is combinational from dout_rdy; 3 samples held when stalled.
module twiddle_angle_encoder
    import twiddle_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*COS_SIN-1:0] din,
    input  logic                 din_vld,
    output logic                 din_rdy,
    output logic [3:0]           dout,
    output logic                 dout_vld,
    input  logic                 dout_rdy,
    output logic                 dout_zero,
    output logic                 dout_exact
);

    logic       s1_vld_q;
    logic       s2_vld_q;
    logic       dout_vld_q;
    fold_t      s1_q;
    fold_t      s1_d;
    sub_t       s2_q;
    sub_t       s2_d;
    angle_idx_t k_q;
    angle_idx_t k_d;
    logic       zero_q;

    logic       s1_en;
    logic       s2_en;
    logic       s3_en;

    logic [COS_SIN-1:0] re_raw;
    logic [COS_SIN-1:0] im_raw;
    logic [COS_SIN-1:0] a_mag;
    logic [COS_SIN-1:0] b_mag;
    logic [1:0]         sub_s;

    // A stage may load when it is empty or its content leaves this cycle
    assign s3_en   = !dout_vld_q || dout_rdy;
    assign s2_en   = !s2_vld_q || s3_en;
    assign s1_en   = !s1_vld_q || s2_en;
    assign din_rdy = s1_en;

    assign re_raw = din[2*COS_SIN-1:COS_SIN];
    assign im_raw = din[COS_SIN-1:0];

    // S1 fold: magnitudes as unsigned so -32768 becomes 32768, then order into x>=y
    always_comb begin
        a_mag     = re_raw[COS_SIN-1] ? (~re_raw + 16'd1) : re_raw;
        b_mag     = im_raw[COS_SIN-1] ? (~im_raw + 16'd1) : im_raw;
        s1_d      = '0;
        s1_d.sr   = re_raw[COS_SIN-1];
        s1_d.si   = im_raw[COS_SIN-1];
        s1_d.sw   = (a_mag < b_mag);
        s1_d.x    = (a_mag < b_mag) ? b_mag : a_mag;
        s1_d.y    = (a_mag < b_mag) ? a_mag : b_mag;
        s1_d.zero = (a_mag == '0) && (b_mag == '0);
    end

    // S1 register
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_q     <= '0;
        end else if (s1_en) begin
            s1_vld_q <= din_vld;
            if (din_vld) begin
                s1_q <= s1_d;
            end
        end
    end

    twiddle_octant_cmp u_octant_cmp (
        .x (s1_q.x),
        .y (s1_q.y),
        .s (sub_s)
    );

    // S2: mirror the sub-sector back across the diagonal when re/im were swapped
    always_comb begin
        s2_d      = '0;
        s2_d.sr   = s1_q.sr;
        s2_d.si   = s1_q.si;
        s2_d.zero = s1_q.zero;
        s2_d.j    = s1_q.sw ? (3'd4 - {1'b0, sub_s}) : {1'b0, sub_s};
    end

    // S2 register
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld_q <= 1'b0;
            s2_q     <= '0;
        end else if (s2_en) begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_q <= s2_d;
            end
        end
    end

    // S3: unfold first-quadrant j into the full circle using the original sign bits
    always_comb begin
        unique case ({s2_q.sr, s2_q.si})
            2'b00:   k_d = {1'b0, s2_q.j};
            2'b10:   k_d = 4'd8 - {1'b0, s2_q.j};
            2'b11:   k_d = 4'd8 + {1'b0, s2_q.j};
            default: k_d = 4'd0 - {1'b0, s2_q.j};
        endcase
        if (s2_q.zero) begin
            k_d = 4'd0;
        end
    end

    // S3 output register; held while dout_vld && !dout_rdy
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_vld_q <= 1'b0;
            k_q        <= '0;
            zero_q     <= 1'b0;
        end else if (s3_en) begin
            dout_vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                k_q    <= k_d;
                zero_q <= s2_q.zero;
            end
        end
    end

    assign dout      = k_q;
    assign dout_vld  = dout_vld_q;
    assign dout_zero = zero_q;

`ifdef TWIDDLE_ANGLE_EXACT_EN
    cplx_t s1_orig_q;
    cplx_t s2_orig_q;
    logic  exact_q;

    // Carry the untouched sample alongside the pipeline for the exact-match compare
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_orig_q <= '0;
            s2_orig_q <= '0;
        end else begin
            if (s1_en && din_vld) begin
                s1_orig_q <= din;
            end
            if (s2_en && s1_vld_q) begin
                s2_orig_q <= s1_orig_q;
            end
        end
    end

    // Exact flag: sample is bit-identical to the decoder constant for the chosen k
    always_ff @(posedge clk) begin
        if (rst) begin
            exact_q <= 1'b0;
        end else if (s3_en && s2_vld_q) begin
            exact_q <= (s2_orig_q == cos_sin(k_d));
        end
    end

    assign dout_exact = exact_q;
`else
    assign dout_exact = 1'b0;
`endif

endmodule

// File: tb/tb_twiddle_angle_encoder.sv
// Directed bench for twiddle_angle_encoder: vector table streamed through a scoreboard,
// plus backpressure and mid-stream reset sequences. Exact-flag expectations follow TWIDDLE_ANGLE_EXACT_EN.
module tb_twiddle_angle_encoder;

`ifdef TWIDDLE_ANGLE_EXACT_EN
    localparam bit EX = 1'b1;
`else
    localparam bit EX = 1'b0;
`endif

    typedef struct {
        logic [31:0] din;
        logic [3:0]  k;
        logic        z;
        logic        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din = '0;
    logic        din_vld = 1'b0;
    logic        din_rdy;
    logic [3:0]  dout;
    logic        dout_vld;
    logic        dout_rdy = 1'b1;
    logic        dout_zero;
    logic        dout_exact;

    twiddle_angle_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_vld    (din_vld),
        .din_rdy    (din_rdy),
        .dout       (dout),
        .dout_vld   (dout_vld),
        .dout_rdy   (dout_rdy),
        .dout_zero  (dout_zero),
        .dout_exact (dout_exact)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    vec_t tv [25];
    vec_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    int   first_acc = -1;
    int   first_out = -1;
    int   last_out = -1;
    int   n_out = 0;

    function automatic vec_t mk(input int re, input int im, input int k, input bit z, input bit e);
        vec_t v;
        v.din = {16'(re), 16'(im)};
        v.k   = 4'(k);
        v.z   = z;
        v.e   = e;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Present one sample, wait (bounded) for acceptance, leave din_vld high for back-to-back use
    task automatic send(input vec_t v);
        int n;
        din     = v.din;
        din_vld = 1'b1;
        n = 0;
        @(negedge clk);
        while (!din_rdy && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!din_rdy) begin
            chk("send_timeout", 0, 1);
        end else begin
            exp_q.push_back(v);
            if (first_acc < 0) first_acc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        logic [5:0] held;

        tv[0]  = mk( 16384,      0,  0, 0, EX);
        tv[1]  = mk( 15136,   6269,  1, 0, EX);
        tv[2]  = mk( 11585,  11585,  2, 0, EX);
        tv[3]  = mk(  6269,  15136,  3, 0, EX);
        tv[4]  = mk(     0,  16384,  4, 0, EX);
        tv[5]  = mk( -6269,  15136,  5, 0, EX);
        tv[6]  = mk(-11585,  11585,  6, 0, EX);
        tv[7]  = mk(-15136,   6269,  7, 0, EX);
        tv[8]  = mk(-16384,      0,  8, 0, EX);
        tv[9]  = mk(-15136,  -6269,  9, 0, EX);
        tv[10] = mk(-11585, -11585, 10, 0, EX);
        tv[11] = mk( -6269, -15136, 11, 0, EX);
        tv[12] = mk(     0, -16384, 12, 0, EX);
        tv[13] = mk(  6269, -15136, 13, 0, EX);
        tv[14] = mk( 11585, -11585, 14, 0, EX);
        tv[15] = mk( 15136,  -6269, 15, 0, EX);
        tv[16] = mk( 16384,   3259,  1, 0, 0);
        tv[17] = mk( 16384,   3258,  0, 0, 0);
        tv[18] = mk( 16384,  10947,  2, 0, 0);
        tv[19] = mk(-16384,  -3259,  9, 0, 0);
        tv[20] = mk( 16384,  -3258,  0, 0, 0);
        tv[21] = mk(     0,      0,  0, 1, 0);
        tv[22] = mk(-32768,      0,  8, 0, 0);
        tv[23] = mk(     0, -32768, 12, 0, 0);
        tv[24] = mk(-32768, -32768, 10, 0, 0);

        // Output monitor: every transfer must match the head of the expected queue
        fork
            forever begin
                @(negedge clk);
                if (!rst && dout_vld && dout_rdy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got k=%0d with nothing outstanding", dout);
                    end else begin
                        vec_t e;
                        e = exp_q.pop_front();
                        checks++;
                        if (dout != e.k || dout_zero != e.z || dout_exact != e.e) begin
                            errors++;
                            $display("FAIL out: got k=%0d zero=%0d exact=%0d, expected k=%0d zero=%0d exact=%0d (din=%h)",
                                     dout, dout_zero, dout_exact, e.k, e.z, e.e, e.din);
                        end
                    end
                    n_out++;
                    if (first_out < 0) first_out = cyc;
                    last_out = cyc;
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_dout", dout, 0);
        chk("rst_dout_vld", dout_vld, 0);
        chk("rst_dout_zero", dout_zero, 0);
        chk("rst_dout_exact", dout_exact, 0);
        chk("rst_din_rdy", din_rdy, 1);

        // Full table streamed back-to-back with no backpressure
        @(posedge clk);
        #1;
        first_acc = -1;
        first_out = -1;
        n_out = 0;
        for (int i = 0; i < 25; i++) send(tv[i]);
        din_vld = 1'b0;
        wait_drain();
        chk("latency", first_out - first_acc, 3);
        chk("throughput_span", last_out - first_out, 24);
        chk("stream_count", n_out, 25);

        // Backpressure: 6 samples, dout_rdy low for 5 cycles once sample 1 sits at the output
        @(posedge clk);
        #1;
        n_out = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(tv[i + 1]);
                din_vld = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 dout_rdy = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    chk("bp_vld", dout_vld, 1);
                    chk("bp_din_rdy", din_rdy, 0);
                    if (c == 0) begin
                        held = {dout_zero, dout_exact, dout};
                        chk("bp_held_k", dout, 2);
                    end else begin
                        chk("bp_stable", {dout_zero, dout_exact, dout}, held);
                    end
                end
                @(posedge clk);
                #1 dout_rdy = 1'b1;
            end
        join
        wait_drain();
        chk("bp_count", n_out, 6);

        // Reset with 3 samples in flight: all must vanish
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(tv[i + 10]);
        rst = 1'b1;
        din_vld = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        n_out = 0;
        @(negedge clk);
        chk("mid_rst_vld", dout_vld, 0);
        chk("mid_rst_din_rdy", din_rdy, 1);
        repeat (10) @(negedge clk);
        chk("mid_rst_no_stale", n_out, 0);

        // Pipeline still usable after reset
        @(posedge clk);
        #1;
        send(tv[5]);
        send(tv[21]);
        din_vld = 1'b0;
        wait_drain();
        chk("post_rst_count", n_out, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
